// File: rtl/pcie_tcap_arb_if.sv
// Stream bundle for pcie_tcap_arb: two per-direction TLP beat inputs and the
// merged capture output.
interface pcie_tcap_arb_if #(
   parameter int unsigned DATA_W = 64
);
   logic [1:0]          in_valid;
   logic [1:0]          in_sop;
   logic [1:0]          in_eop;
   logic [2*DATA_W-1:0] in_data;
   logic [1:0]          in_ready;
   logic                out_valid;
   logic                out_sop;
   logic                out_eop;
   logic [DATA_W-1:0]   out_data;
   logic                out_ready;

   modport master (
      output in_valid, in_sop, in_eop, in_data, out_ready,
      input  in_ready, out_valid, out_sop, out_eop, out_data
   );

   modport slave (
      input  in_valid, in_sop, in_eop, in_data, out_ready,
      output in_ready, out_valid, out_sop, out_eop, out_data
   );
endinterface

// File: rtl/pcie_tcap_arb.sv
// Packet-level round-robin merge of two TLP beat streams into one tcap capture
// stream; each packet is preceded by a timestamped global header beat.
module pcie_tcap_arb #(
   parameter int unsigned DATA_W = 64,
   parameter logic [1:0]  DIR_P0 = 2'b01,
   parameter logic [1:0]  DIR_P1 = 2'b10
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   pcie_tcap_arb_if.slave bus,
   output logic [39:0]    ts_now,
   output logic [15:0]    drop_cnt
);
   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   state_t            state;
   logic              g;
   logic              rr_last;
   logic              hdr_vld;
   logic [DATA_W-1:0] hdr_data;
   logic [DATA_W-1:0] hdr_next;
   logic [DATA_W-1:0] g_data;
   logic [1:0]        cand;
   logic [1:0]        orphan;
   logic              pick;
   logic [16:0]       drop_sum;
   logic [15:0]       drop_next;

   always_comb begin
      cand     = bus.in_valid & bus.in_sop & {2{en}};
      pick     = (cand == 2'b11) ? ~rr_last : cand[1];
      hdr_next = '0;
      hdr_next[DATA_W-1 -: 48] = {3'b001, (pick ? DIR_P1 : DIR_P0), 3'b000, ts_now};
      // The port holding the grant (HDR or DATA) is never treated as orphan.
      orphan   = bus.in_valid & ~bus.in_sop;
      if (state != IDLE) orphan[g] = 1'b0;
      drop_sum  = {1'b0, drop_cnt} + {16'd0, orphan[0]} + {16'd0, orphan[1]};
      drop_next = drop_sum[16] ? '1 : drop_sum[15:0];
      g_data    = g ? bus.in_data[2*DATA_W-1 -: DATA_W] : bus.in_data[DATA_W-1:0];
   end

   always_comb begin
      bus.in_ready  = orphan;
      bus.out_valid = hdr_vld;
      bus.out_sop   = hdr_vld;
      bus.out_eop   = 1'b0;
      bus.out_data  = hdr_data;
      if (state == DATA) begin
         bus.out_valid   = bus.in_valid[g];
         bus.out_eop     = bus.in_eop[g];
         bus.out_data    = g_data;
         bus.in_ready[g] = bus.out_ready;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         g        <= 1'b0;
         rr_last  <= 1'b1;
         hdr_vld  <= 1'b0;
         hdr_data <= '0;
         ts_now   <= '0;
         drop_cnt <= '0;
      end else begin
         ts_now   <= ts_now + 40'd1;
         drop_cnt <= drop_next;
         case (state)
            IDLE: begin
               if (|cand) begin
                  g        <= pick;
                  rr_last  <= pick;
                  hdr_data <= hdr_next;
                  hdr_vld  <= 1'b1;
                  state    <= HDR;
               end
            end
            HDR: begin
               if (bus.out_ready) begin
                  hdr_vld  <= 1'b0;
                  hdr_data <= '0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (bus.in_valid[g] && bus.out_ready && bus.in_eop[g]) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pcie_tcap_arb.sv
// Directed bench for pcie_tcap_arb: cycle-level reference model compared every
// cycle, plus hand-computed header, order, drop and timestamp expectations.
module tb_pcie_tcap_arb;
   localparam int unsigned DW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          v0, v1, s0, s1, e0, e1, ordy;
   logic [DW-1:0] d0, d1;
   logic [39:0]   ts_now;
   logic [15:0]   drop_cnt;

   int            n_pass  = 0;
   int            n_total = 0;
   bit            chk_on  = 1'b0;
   logic [65:0]   obeats[$];
   logic [63:0]   hdrs[$];

   // reference model state
   int            m_owner = -1;
   bit            m_hdr   = 1'b0;
   int            m_last  = 1;
   logic [39:0]   m_ts    = '0;
   logic [39:0]   m_hts   = '0;
   logic [1:0]    m_hdir  = '0;
   int            m_drop  = 0;
   int            ts_ld_seq = 0, ts_ld_seen = 0, drop_ld_seq = 0, drop_ld_seen = 0;
   logic [39:0]   ts_ld_val   = '0;
   logic [15:0]   drop_ld_val = '0;

   pcie_tcap_arb_if #(.DATA_W(DW)) bus ();

   assign bus.in_valid  = {v1, v0};
   assign bus.in_sop    = {s1, s0};
   assign bus.in_eop    = {e1, e0};
   assign bus.in_data   = {d1, d0};
   assign bus.out_ready = ordy;

   pcie_tcap_arb #(.DATA_W(DW), .DIR_P0(2'b01), .DIR_P1(2'b10)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .bus(bus), .ts_now(ts_now), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit orph(input int p);
      bit v, s;
      v = (p == 0) ? v0 : v1;
      s = (p == 0) ? s0 : s1;
      return v && !s && (m_owner != p);
   endfunction

   // Model: one packet owner at a time, header first, round robin at boundaries.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_owner = -1; m_hdr = 1'b0; m_last = 1; m_ts = '0; m_drop = 0;
         m_hts = '0; m_hdir = '0;
      end else begin : upd
         int nd;
         bit c0, c1;
         nd = int'(orph(0)) + int'(orph(1));
         if (drop_ld_seq != drop_ld_seen) begin
            m_drop = int'(drop_ld_val);
            drop_ld_seen = drop_ld_seq;
         end
         m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
         if (ts_ld_seq != ts_ld_seen) begin
            m_ts = ts_ld_val;
            ts_ld_seen = ts_ld_seq;
         end
         if (m_owner < 0) begin
            c0 = en && v0 && s0;
            c1 = en && v1 && s1;
            if (c0 || c1) begin
               m_owner = (c0 && c1) ? 1 - m_last : (c1 ? 1 : 0);
               m_last  = m_owner;
               m_hdr   = 1'b1;
               m_hts   = m_ts;
               m_hdir  = (m_owner == 0) ? 2'b01 : 2'b10;
            end
         end else if (m_hdr) begin
            if (ordy) m_hdr = 1'b0;
         end else if (((m_owner == 0) ? v0 : v1) && ordy && ((m_owner == 0) ? e0 : e1)) begin
            m_owner = -1;
         end
         m_ts = m_ts + 40'd1;
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) begin : cmp
         logic          ev, es, ee;
         logic [63:0]   ed;
         logic [1:0]    er;
         ev = 1'b0; es = 1'b0; ee = 1'b0; ed = '0;
         er = {orph(1), orph(0)};
         if (m_owner >= 0 && m_hdr) begin
            ev = 1'b1; es = 1'b1;
            ed = {3'b001, m_hdir, 3'b000, m_hts, 16'h0000};
         end else if (m_owner >= 0) begin
            ev = (m_owner == 0) ? v0 : v1;
            ee = (m_owner == 0) ? e0 : e1;
            ed = (m_owner == 0) ? d0 : d1;
            er[m_owner] = ordy;
         end
         chk("out_valid", bus.out_valid, ev);
         chk("out_sop", bus.out_sop, es);
         chk("out_eop", bus.out_eop, ee);
         chk("out_data", bus.out_data, ed);
         chk("in_ready", bus.in_ready, er);
         chk("ts_now", ts_now, m_ts);
         chk("drop_cnt", drop_cnt, m_drop[15:0]);
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
         obeats.push_back({bus.out_sop, bus.out_eop, bus.out_data});
         if (bus.out_sop) hdrs.push_back(bus.out_data);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic v, input logic s, input logic e, input logic [63:0] d);
      if (p == 0) begin v0 = v; s0 = s; e0 = e; d0 = d; end
      else        begin v1 = v; s1 = s; e1 = e; d1 = d; end
   endtask

   task automatic wait_acc(input int p);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge clk);
         if (bus.in_ready[p]) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("accept_in_time", ok, 1'b1);
   endtask

   task automatic send_pkt(input int p, input int len, input logic [63:0] base);
      for (int i = 0; i < len; i++) begin
         drive(p, 1'b1, i == 0, i == len - 1, base + 64'(i));
         wait_acc(p);
      end
      drive(p, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic wait_beats(input int ob, input int n);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge clk);
         if (obeats.size() - ob >= n) ok = 1'b1;
      end
      chk("beats_in_time", ok, 1'b1);
   endtask

   initial begin : stim
      int ob, hb, nd;
      logic [63:0] exp2[8];
      logic [63:0] got;
      rst_n = 1'b1; en = 1'b1; ordy = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0, '0);
      drive(1, 1'b0, 1'b0, 1'b0, '0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_data", bus.out_data, 64'h0);
      chk("rst_in_ready", bus.in_ready, 2'b00);
      chk("rst_ts_now", ts_now, 40'd0);
      chk("rst_drop_cnt", drop_cnt, 16'd0);
      chk_on = 1'b1;
      cyc(); cyc();
      rst_n = 1'b1;

      // single 3-beat packet from port 0, SOP seen while ts_now = 100
      for (int k = 0; k < 300 && ts_now != 40'd100; k++) cyc();
      chk("ts_reach_100", ts_now, 40'd100);
      ob = obeats.size();
      send_pkt(0, 3, 64'hA0);
      cyc(); cyc();
      chk("t1_beats", obeats.size() - ob, 4);
      chk("t1_hdr", obeats[ob], {2'b10, 64'h2800000000640000});
      chk("t1_b0", obeats[ob+1], {2'b00, 64'hA0});
      chk("t1_b1", obeats[ob+2], {2'b00, 64'hA1});
      chk("t1_b2", obeats[ob+3], {2'b01, 64'hA2});

      // simultaneous SOPs after reset: order 0,1,0,1
      rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
      ob = obeats.size(); hb = hdrs.size();
      fork
         begin send_pkt(0, 2, 64'hB0); send_pkt(0, 2, 64'hB2); end
         begin send_pkt(1, 2, 64'hC0); send_pkt(1, 2, 64'hC2); end
      join
      cyc(); cyc();
      chk("t2_hdrs", hdrs.size() - hb, 4);
      chk("t2_ver", hdrs[hb][63:61], 3'b001);
      chk("t2_dir0", hdrs[hb][60:59], 2'b01);
      chk("t2_dir1", hdrs[hb+1][60:59], 2'b10);
      chk("t2_dir2", hdrs[hb+2][60:59], 2'b01);
      chk("t2_dir3", hdrs[hb+3][60:59], 2'b10);
      exp2 = '{64'hB0, 64'hB1, 64'hC0, 64'hC1, 64'hB2, 64'hB3, 64'hC2, 64'hC3};
      nd = 0;
      for (int i = ob; i < obeats.size(); i++) begin
         if (!obeats[i][65] && nd < 8) begin
            got = obeats[i][63:0];
            chk("t2_order", got, exp2[nd]);
            nd++;
         end
      end
      chk("t2_data_beats", nd, 8);

      // backpressure in HDR and mid-DATA
      ob = obeats.size();
      ordy = 1'b0;
      fork
         send_pkt(0, 4, 64'hD0);
         begin
            for (int k = 0; k < 50 && !bus.out_valid; k++) @(negedge clk);
            repeat (5) @(posedge clk);
            #1 ordy = 1'b1;
            wait_beats(ob, 3);
            cyc();
            ordy = 1'b0;
            repeat (5) cyc();
            ordy = 1'b1;
         end
      join
      cyc();
      chk("t3_beats", obeats.size() - ob, 5);
      chk("t3_hdr_sop", obeats[ob][65], 1'b1);
      for (int i = 0; i < 4; i++) begin
         got = obeats[ob+1+i][63:0];
         chk("t3_data", got, 64'hD0 + 64'(i));
         chk("t3_eop", obeats[ob+1+i][64], i == 3);
      end

      // orphans on port 1 while port 0 is mid-packet, then saturation
      ob = obeats.size();
      fork
         send_pkt(0, 5, 64'hE0);
         begin
            cyc(); cyc();
            for (int i = 0; i < 3; i++) begin
               drive(1, 1'b1, 1'b0, 1'b0, 64'hF0 + 64'(i));
               wait_acc(1);
            end
            drive(1, 1'b0, 1'b0, 1'b0, '0);
         end
      join
      cyc();
      chk("t4_drop3", drop_cnt, 16'd3);
      chk("t4_beats", obeats.size() - ob, 6);
      for (int i = 0; i < 5; i++) begin
         got = obeats[ob+1+i][63:0];
         chk("t4_p0_data", got, 64'hE0 + 64'(i));
      end
      chk_on = 1'b0;
      drive(0, 1'b1, 1'b0, 1'b0, 64'h11);
      drive(1, 1'b1, 1'b0, 1'b0, 64'h22);
      force dut.drop_cnt = 16'hFFFE;
      #1 release dut.drop_cnt;
      drop_ld_val = 16'hFFFE;
      drop_ld_seq++;
      cyc();
      chk_on = 1'b1;
      chk("t4_sat1", drop_cnt, 16'hFFFF);
      cyc();
      chk("t4_sat2", drop_cnt, 16'hFFFF);
      drive(0, 1'b0, 1'b0, 1'b0, '0);
      drive(1, 1'b0, 1'b0, 1'b0, '0);
      cyc();

      // timestamp wrap and a packet stamped with ts = 0
      chk_on = 1'b0;
      force dut.ts_now = 40'hFF_FFFF_FFFE;
      #1 release dut.ts_now;
      ts_ld_val = 40'hFF_FFFF_FFFE;
      ts_ld_seq++;
      cyc();
      chk_on = 1'b1;
      chk("t5_ts_max", ts_now, 40'hFF_FFFF_FFFF);
      cyc();
      chk("t5_ts_zero", ts_now, 40'd0);
      hb = hdrs.size();
      send_pkt(1, 2, 64'h50);
      cyc();
      chk("t5_hdr_ts0", hdrs[hb], 64'h3000000000000000);

      // en dropped mid-packet: packet completes, pending SOP waits for en
      ob = obeats.size(); hb = hdrs.size();
      fork
         send_pkt(0, 4, 64'h60);
         begin
            wait_beats(ob, 2);
            cyc();
            en = 1'b0;
            cyc();
            send_pkt(1, 2, 64'h70);
         end
         begin
            wait_beats(ob, 5);
            repeat (6) cyc();
            chk("t6_no_hdr_while_off", hdrs.size() - hb, 1);
            en = 1'b1;
         end
      join
      cyc(); cyc();
      chk("t6_hdrs", hdrs.size() - hb, 2);
      chk("t6_dir_p1", hdrs[hb+1][60:59], 2'b10);

      // async reset mid-packet truncates output and clears counters at once
      ob = obeats.size(); hb = hdrs.size();
      fork
         send_pkt(0, 4, 64'h80);
         begin
            wait_beats(ob, 2);
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("t7_rst_valid", bus.out_valid, 1'b0);
            chk("t7_rst_sop", bus.out_sop, 1'b0);
            chk("t7_rst_drop", drop_cnt, 16'd0);
            chk("t7_rst_ts", ts_now, 40'd0);
            @(posedge clk);
            #2 rst_n = 1'b1;
         end
      join
      repeat (3) cyc();
      chk("t7_one_hdr", hdrs.size() - hb, 1);
      nd = 0;
      for (int i = ob; i < obeats.size(); i++) if (obeats[i][64]) nd++;
      chk("t7_no_eop", nd, 0);

      repeat (2) cyc();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
